// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: fixed/rotating priority over synchronized DREQ plus software requests, owns HRQ/HLDA and DACK.
// DREQ edge to hrqReq takes DREQ_SYNC+1 edges (software request: 1); a grant is held until xferDone, HLDA loss or withdrawal in REQ.
module dma_priority_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DREQ_SYNC = 2,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] softReqReg,
  input  logic              ctrlEnable,
  input  logic              rotatingPri,
  input  logic              dreqActiveLow,
  input  logic              dackActiveLow,
  input  logic              HLDA,
  input  logic              assertDACK,
  input  logic              xferDone,
  output logic              hrqReq,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantCh,
  output logic [CH_W-1:0]   topPriCh
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    REQ   = 3'b010,
    GRANT = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic              hrq_q, hrq_d;
  logic              gnt_vld_q, gnt_vld_d;
  logic [CH_W-1:0]   gnt_ch_q, gnt_ch_d;
  logic [CH_W-1:0]   top_pri_q, top_pri_d;
  logic [NUM_CH-1:0] sync_q [DREQ_SYNC];
  logic [NUM_CH-1:0] sync_d [DREQ_SYNC];
  logic [NUM_CH-1:0] pending;
  logic [CH_W-1:0]   winner;
  logic [CH_W-1:0]   idx;
  logic              win_found;
  logic              dack_on;

  // DREQ is normalised to active-high before the synchronizer chain
  always_comb begin
    sync_d[0] = DREQ ^ {NUM_CH{dreqActiveLow}};
    for (int i = 1; i < DREQ_SYNC; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign pending = (sync_q[DREQ_SYNC-1] & ~maskReg) | softReqReg;

  // Search starts at topPriCh and wraps; power-of-two NUM_CH makes the wrap a truncation
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = top_pri_q + CH_W'(i);
      if (!win_found && pending[idx]) begin
        winner    = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hrq_d     = hrq_q;
    gnt_vld_d = gnt_vld_q;
    gnt_ch_d  = gnt_ch_q;
    top_pri_d = rotatingPri ? top_pri_q : '0;
    case (state_q)
      IDLE: begin
        if (ctrlEnable && win_found) begin
          gnt_ch_d  = winner;
          gnt_vld_d = 1'b1;
          hrq_d     = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (HLDA) begin
          state_d = GRANT;
        end else if (!pending[gnt_ch_q]) begin
          hrq_d     = 1'b0;
          gnt_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      GRANT: begin
        if (xferDone) begin
          hrq_d     = 1'b0;
          gnt_vld_d = 1'b0;
          state_d   = IDLE;
          if (rotatingPri) top_pri_d = gnt_ch_q + CH_W'(1);
        end else if (!HLDA) begin
          hrq_d     = 1'b0;
          gnt_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        hrq_d     = 1'b0;
        gnt_vld_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      hrq_q     <= 1'b0;
      gnt_vld_q <= 1'b0;
      gnt_ch_q  <= '0;
      top_pri_q <= '0;
      for (int i = 0; i < DREQ_SYNC; i++) sync_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      hrq_q     <= hrq_d;
      gnt_vld_q <= gnt_vld_d;
      gnt_ch_q  <= gnt_ch_d;
      top_pri_q <= top_pri_d;
      for (int i = 0; i < DREQ_SYNC; i++) sync_q[i] <= sync_d[i];
    end
  end

  // HLDA gating keeps DACK off the instant the CPU reclaims the bus
  assign dack_on = (state_q == GRANT) && HLDA && assertDACK;

  always_comb begin
    DACK = {NUM_CH{dackActiveLow}};
    if (dack_on) DACK[gnt_ch_q] = ~dackActiveLow;
  end

  assign hrqReq     = hrq_q;
  assign grantValid = gnt_vld_q;
  assign grantCh    = gnt_ch_q;
  assign topPriCh   = top_pri_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with NUM_CH=4, DREQ_SYNC=2.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ, maskReg, softReqReg;
  logic       ctrlEnable, rotatingPri, dreqActiveLow, dackActiveLow;
  logic       HLDA, assertDACK, xferDone;
  logic       hrqReq, grantValid;
  logic [3:0] DACK;
  logic [1:0] grantCh, topPriCh;

  int vec_cnt = 0;
  int err_cnt = 0;

  dma_priority_arbiter #(.NUM_CH(4), .DREQ_SYNC(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .maskReg(maskReg),
    .softReqReg(softReqReg), .ctrlEnable(ctrlEnable), .rotatingPri(rotatingPri),
    .dreqActiveLow(dreqActiveLow), .dackActiveLow(dackActiveLow), .HLDA(HLDA),
    .assertDACK(assertDACK), .xferDone(xferDone), .hrqReq(hrqReq), .DACK(DACK),
    .grantValid(grantValid), .grantCh(grantCh), .topPriCh(topPriCh)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // From REQ: grant bus, complete one transfer, CPU releases HLDA
  task automatic do_xfer();
    HLDA = 1'b1;
    tick();
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;
    HLDA     = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; DREQ = 4'h0; maskReg = 4'h0; softReqReg = 4'h0;
    ctrlEnable = 1'b1; rotatingPri = 1'b0; dreqActiveLow = 1'b0; dackActiveLow = 1'b1;
    HLDA = 1'b0; assertDACK = 1'b0; xferDone = 1'b0;

    // T1 reset, before and after clock edges
    #2;
    chk("rst_dack_noclk", DACK, 4'hF);
    chk("rst_hrq_noclk", hrqReq, 1'b0);
    chk("rst_gv_noclk", grantValid, 1'b0);
    tick(); tick();
    chk("rst_dack", DACK, 4'hF);
    chk("rst_gch", grantCh, 2'd0);
    chk("rst_top", topPriCh, 2'd0);
    RESET_N = 1'b1;
    tick();

    // T2 latency through synchronizer, then DACK
    dackActiveLow = 1'b0;
    DREQ = 4'b0100;
    tick(); chk("lat_e1", hrqReq, 1'b0);
    tick(); chk("lat_e2", hrqReq, 1'b0);
    tick(); chk("lat_e3", hrqReq, 1'b1);
    chk("lat_gch", grantCh, 2'd2);
    chk("lat_gv", grantValid, 1'b1);
    assertDACK = 1'b1; #1;
    chk("dack_in_req", DACK, 4'b0000);
    assertDACK = 1'b0;
    HLDA = 1'b1;
    tick();
    assertDACK = 1'b1; #1;
    chk("dack_grant", DACK, 4'b0100);
    DREQ = 4'b0000;
    tick(); tick(); tick();
    chk("grant_hold_hrq", hrqReq, 1'b1);
    assertDACK = 1'b0;
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0; HLDA = 1'b0;
    chk("done_hrq", hrqReq, 1'b0);
    chk("done_gv", grantValid, 1'b0);
    chk("done_top_fixed", topPriCh, 2'd0);
    tick();
    chk("idle_quiet", hrqReq, 1'b0);

    // T3 fixed priority; xferDone outside GRANT ignored
    softReqReg = 4'b1010;
    tick();
    chk("fix_gch1", grantCh, 2'd1);
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0;
    chk("xd_in_req_hrq", hrqReq, 1'b1);
    chk("xd_in_req_gv", grantValid, 1'b1);
    do_xfer();
    chk("fix_top", topPriCh, 2'd0);
    tick();
    chk("fix_gch2", grantCh, 2'd1);
    chk("fix_rearb", hrqReq, 1'b1);
    do_xfer();

    // T4 rotation over all-requesting channels
    rotatingPri = 1'b1;
    softReqReg  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rot_gch%0d", i), grantCh, 32'((i) % 4));
      do_xfer();
      chk($sformatf("rot_top%0d", i), topPriCh, 32'((i + 1) % 4));
    end
    softReqReg  = 4'b0000;
    rotatingPri = 1'b0;
    tick();
    chk("fixed_forces_top0", topPriCh, 2'd0);

    // T5 mask, software override, withdrawal, HLDA beats withdrawal
    dackActiveLow = 1'b1;
    dreqActiveLow = 1'b1;
    DREQ    = 4'b1110;
    maskReg = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("masked_hrq", hrqReq, 1'b0);
    softReqReg = 4'b0001;
    tick();
    chk("soft_hrq", hrqReq, 1'b1);
    chk("soft_gch", grantCh, 2'd0);
    softReqReg = 4'b0000;
    tick();
    chk("withdraw_hrq", hrqReq, 1'b0);
    chk("withdraw_gv", grantValid, 1'b0);
    softReqReg = 4'b0001;
    tick();
    softReqReg = 4'b0000;
    HLDA = 1'b1;
    tick();
    chk("hlda_wins_hrq", hrqReq, 1'b1);
    assertDACK = 1'b1; #1;
    chk("hlda_wins_dack", DACK, 4'b1110);
    assertDACK = 1'b0;
    xferDone = 1'b1;
    tick();
    xferDone = 1'b0; HLDA = 1'b0;
    DREQ = 4'b1111;
    tick(); tick(); tick();
    maskReg = 4'b0000;
    tick();
    chk("unmask_idle", hrqReq, 1'b0);

    // T6 abort keeps topPriCh; async reset mid-GRANT
    rotatingPri = 1'b1;
    softReqReg  = 4'b0010;
    tick();
    softReqReg = 4'b0000;
    do_xfer();
    chk("pre_abort_top", topPriCh, 2'd2);
    softReqReg = 4'b0100;
    tick();
    chk("abort_gch", grantCh, 2'd2);
    HLDA = 1'b1;
    tick();
    assertDACK = 1'b1; #1;
    chk("abort_dack_on", DACK, 4'b1011);
    HLDA = 1'b0; #1;
    chk("abort_dack_hlda", DACK, 4'hF);
    softReqReg = 4'b0000;
    tick();
    chk("abort_hrq", hrqReq, 1'b0);
    chk("abort_gv", grantValid, 1'b0);
    chk("abort_top", topPriCh, 2'd2);
    chk("abort_dack", DACK, 4'hF);
    assertDACK = 1'b0;
    softReqReg = 4'b1000;
    tick();
    HLDA = 1'b1;
    tick();
    assertDACK = 1'b1; #1;
    chk("rstmid_dack_on", DACK, 4'b0111);
    #1 RESET_N = 1'b0;
    #1;
    chk("rstmid_dack", DACK, 4'hF);
    chk("rstmid_hrq", hrqReq, 1'b0);
    chk("rstmid_gv", grantValid, 1'b0);
    chk("rstmid_gch", grantCh, 2'd0);
    chk("rstmid_top", topPriCh, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
